speed_pi_ctrl: RTL and testbench

- Closed-loop speed regulator that sits directly downstream of the speedmeter.
- It captures the 8-bit speed count S when the speedmeter's measurement gate pe falls, and runs a shift-gain PI update against a setpoint.
- The resulting duty is driven out as a glitch-free PWM to the motor driver.
- One PI update per measurement window.

---
 rtl/speed_pi_ctrl.sv | 146 ++++++++++++++
 tb/tb_speed_pi_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_pi_ctrl.sv
// Speed PI regulator: one shift-gain PI update per speedmeter window,
// committed duty driven out as a period-aligned PWM.
module speed_pi_ctrl #(
  parameter int unsigned SPEED_W  = 8,
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned KP_SHIFT = 2,
  parameter int unsigned KI_SHIFT = 4,
  parameter int unsigned INT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pe,
  input  logic [SPEED_W-1:0] S,
  input  logic [SPEED_W-1:0] setpoint,
  input  logic               enable,
  output logic [DUTY_W-1:0]  duty,
  output logic               pwm,
  output logic               sat,
  output logic               busy
);

  localparam int unsigned U_W = INT_W + SPEED_W + KP_SHIFT + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]               state;
  logic                     pe_d, fall, sat_hi;
  logic [SPEED_W-1:0]       s_lat, sp_lat;
  logic signed [SPEED_W:0]  err, err_c;
  logic signed [INT_W-1:0]  integ, integ_n, integ_c, int_sh;
  logic signed [INT_W:0]    isum;
  logic signed [U_W-1:0]    err_ext, int_ext, u;
  logic                     err_pos, err_neg, hold;
  logic [DUTY_W-1:0]        duty_c, pwm_cnt, duty_act;
  logic                     sat_c, sat_hi_c;

  assign fall  = pe_d & ~pe;
  assign err_c = $signed({1'b0, sp_lat}) - $signed({1'b0, s_lat});

  // Anti-windup: freeze the integrator while the error pushes further into the clamp.
  assign err_neg = err_c[SPEED_W];
  assign err_pos = ~err_c[SPEED_W] & (|err_c);
  assign hold    = sat & ((sat_hi & err_pos) | (~sat_hi & err_neg));
  assign isum    = {integ[INT_W-1], integ} + {{(INT_W-SPEED_W){err_c[SPEED_W]}}, err_c};

  always_comb begin
    integ_c = integ;
    if (!hold) begin
      if (isum[INT_W] != isum[INT_W-1]) begin
        integ_c = isum[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
      end else begin
        integ_c = isum[INT_W-1:0];
      end
    end
  end

  assign int_sh  = integ_n >>> KI_SHIFT;
  assign err_ext = {{(U_W-SPEED_W-1){err[SPEED_W]}}, err};
  assign int_ext = {{(U_W-INT_W){int_sh[INT_W-1]}}, int_sh};
  assign u       = (err_ext <<< KP_SHIFT) + int_ext;

  always_comb begin
    duty_c   = u[DUTY_W-1:0];
    sat_c    = 1'b0;
    sat_hi_c = 1'b0;
    if (u[U_W-1]) begin
      duty_c = '0;
      sat_c  = 1'b1;
    end else if (|u[U_W-2:DUTY_W]) begin
      duty_c   = '1;
      sat_c    = 1'b1;
      sat_hi_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pe_d    <= 1'b0;
      s_lat   <= '0;
      sp_lat  <= '0;
      err     <= '0;
      integ   <= '0;
      integ_n <= '0;
      duty    <= '0;
      sat     <= 1'b0;
      sat_hi  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pe_d <= pe;
      if (!enable) begin
        state  <= IDLE;
        integ  <= '0;
        duty   <= '0;
        sat    <= 1'b0;
        sat_hi <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              s_lat  <= S;
              sp_lat <= setpoint;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
          CALC: begin
            err     <= err_c;
            integ_n <= integ_c;
            state   <= UPDATE;
          end
          UPDATE: begin
            duty   <= duty_c;
            sat    <= sat_c;
            sat_hi <= sat_hi_c;
            integ  <= integ_n;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // duty_act only follows duty at the period boundary so a period is never split.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      if (!enable) begin
        duty_act <= '0;
      end else if (&pwm_cnt) begin
        duty_act <= duty;
      end
      pwm <= enable & (pwm_cnt < duty_act);
    end
  end

endmodule

// File: tb/tb_speed_pi_ctrl.sv
// Bench for speed_pi_ctrl: vector table, hand-written corner sequences and
// random windows against an integer PI model plus a per-cycle PWM model.
module tb_speed_pi_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pe = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] S = '0;
  logic [7:0] setpoint = '0;
  logic [7:0] duty;
  logic       pwm, sat, busy;

  speed_pi_ctrl #(
    .SPEED_W (8),
    .DUTY_W  (8),
    .KP_SHIFT(2),
    .KI_SHIFT(4),
    .INT_W   (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pe      (pe),
    .S       (S),
    .setpoint(setpoint),
    .enable  (enable),
    .duty    (duty),
    .pwm     (pwm),
    .sat     (sat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PI reference model in plain integer arithmetic
  int   m_integ;
  bit   m_sat, m_sat_hi;
  int   m_duty;
  logic [7:0] exp_duty = '0;

  function automatic int floor_div16(input int x);
    int q;
    q = x / 16;
    if (x < 0 && q * 16 != x) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_integ = 0; m_sat = 0; m_sat_hi = 0; m_duty = 0;
  endtask

  task automatic model_step(input int sp, input int s);
    int err, u;
    err = sp - s;
    if (!(m_sat && ((m_sat_hi && err > 0) || (!m_sat_hi && err < 0)))) begin
      m_integ = m_integ + err;
      if (m_integ > 32767) m_integ = 32767;
      if (m_integ < -32768) m_integ = -32768;
    end
    u = err * 4 + floor_div16(m_integ);
    if (u < 0) begin
      m_duty = 0; m_sat = 1; m_sat_hi = 0;
    end else if (u > 255) begin
      m_duty = 255; m_sat = 1; m_sat_hi = 1;
    end else begin
      m_duty = u; m_sat = 0; m_sat_hi = 0;
    end
  endtask

  // PWM model: edges since reset release; the phase of a period is edges mod 256
  int unsigned edges;
  logic [7:0]  period_duty;
  logic        ref_pwm;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edges       <= 0;
      period_duty <= '0;
      ref_pwm     <= 1'b0;
    end else begin
      edges <= edges + 1;
      if (!enable) period_duty <= '0;
      else if ((edges + 1) % 256 == 0) period_duty <= exp_duty;
      ref_pwm <= enable && ((edges % 256) < period_duty);
    end
  end

  always @(negedge clk) check("pwm cycle", pwm, ref_pwm);

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    exp_duty = '0;
    for (int i = 0; i < 4; i++) begin
      pe = ~pe;
      @(negedge clk);
      check("reset duty", duty, 0);
      check("reset pwm", pwm, 0);
      check("reset busy", busy, 0);
      check("reset sat", sat, 0);
    end
    pe = 1'b1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_window(input int sp, input int s, input bit dbl, input string tag);
    setpoint = sp[7:0];
    S = s[7:0];
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    @(negedge clk);
    check({tag, " busy1"}, busy, 1);
    check({tag, " duty1"}, duty, exp_duty);
    if (dbl) pe = 1'b1;
    @(negedge clk);
    check({tag, " busy2"}, busy, 1);
    check({tag, " duty2"}, duty, exp_duty);
    if (dbl) pe = 1'b0;
    @(negedge clk);
    model_step(sp, s);
    exp_duty = m_duty[7:0];
    check({tag, " busy3"}, busy, 0);
    check({tag, " duty"}, duty, m_duty);
    check({tag, " sat"}, sat, m_sat);
    pe = 1'b1;
    @(negedge clk);
    check({tag, " busy4"}, busy, 0);
    check({tag, " duty4"}, duty, m_duty);
  endtask

  typedef struct {
    bit rst;
    int sp;
    int s;
    int duty;
    int sat;
  } vec_t;

  vec_t tbl[9];
  int   hi_cnt;

  initial begin
    tbl[0] = '{1, 100,  80,  81, 0};
    tbl[1] = '{1, 255,   0, 255, 1};
    tbl[2] = '{0, 255,   0, 255, 1};
    tbl[3] = '{0, 255,   0, 255, 1};
    tbl[4] = '{0, 100, 100,  15, 0};   // integrator held at 255 by anti-windup
    tbl[5] = '{1,  50, 100,   0, 1};
    tbl[6] = '{0, 100, 100,   0, 1};
    tbl[7] = '{0, 120, 100,  78, 0};
    tbl[8] = '{0, 100, 100,   0, 1};

    enable = 1'b1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      run_window(tbl[i].sp, tbl[i].s, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table duty", i), duty, tbl[i].duty);
      check($sformatf("vec%0d table sat", i), sat, tbl[i].sat);
    end

    // PWM high count over one full period
    do_reset();
    run_window(100, 80, 1'b0, "step");
    while (edges % 256 != 1) @(negedge clk);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      hi_cnt += int'(pwm);
      @(negedge clk);
    end
    check("step pwm highs", hi_cnt, 81);

    // Commit lands mid-period with a second fall during busy
    while (edges % 256 != 97) @(negedge clk);
    run_window(200, 150, 1'b1, "glitch");
    check("glitch duty", duty, 204);
    hi_cnt = 0;
    while (edges % 256 != 1) begin
      hi_cnt += int'(pwm);
      @(negedge clk);
    end
    check("glitch rest of period", hi_cnt, 0);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      hi_cnt += int'(pwm);
      @(negedge clk);
    end
    check("glitch next period", hi_cnt, 204);
    repeat (4) begin
      @(negedge clk);
      check("glitch single update busy", busy, 0);
      check("glitch single update duty", duty, 204);
    end

    // enable dropped in CALC
    do_reset();
    run_window(100, 80, 1'b0, "pre");
    setpoint = 8'd100; S = 8'd80; pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    @(negedge clk);
    check("calc busy", busy, 1);
    enable = 1'b0;
    exp_duty = '0;
    model_reset();
    @(negedge clk);
    check("disable busy", busy, 0);
    check("disable duty", duty, 0);
    check("disable sat", sat, 0);
    repeat (3) @(negedge clk);
    check("disable pwm", pwm, 0);
    check("disable duty hold", duty, 0);
    enable = 1'b1;
    pe = 1'b1;
    @(negedge clk);
    run_window(100, 80, 1'b0, "reen");
    check("reenable duty", duty, 81);

    // Reset during an update
    setpoint = 8'd255; S = 8'd0; pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset duty", duty, 0);
    do_reset();
    run_window(100, 80, 1'b0, "postrst");
    check("postrst duty", duty, 81);

    // Random windows against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int s, sp;
      s = int'($urandom_range(0, 255));
      if (i % 2 == 0) sp = int'($urandom_range(0, 255));
      else begin
        sp = s + int'($urandom_range(0, 60)) - 30;
        if (sp < 0) sp = 0;
        if (sp > 255) sp = 255;
      end
      run_window(sp, s, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      repeat (int'($urandom_range(0, 20))) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
